// File: rtl/lower_layer_sender.sv
// Collects SIZE unsorted elements, sorts them with odd-even transposition,
// then presents them one at a time in ascending order to an upper merge layer.
module lower_layer_sender #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  shift,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  done
);

    localparam int CW = $clog2(SIZE + 1);
    localparam int IW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
    localparam logic [CW-1:0] FULL = CW'(SIZE);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_SORT,
        S_SEND
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_done;
    logic [CW-1:0]         r_wr_cnt;
    logic [CW-1:0]         r_pass_cnt;
    logic [CW-1:0]         r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_buf  [SIZE];
    logic [DATA_WIDTH-1:0] w_pass [SIZE];

    // wr_cnt==FULL marks the hand-off cycle into SORT; nothing is accepted then
    assign in_ready = (r_state == S_COLLECT) && (r_wr_cnt != FULL);
    assign done     = r_done;
    assign dout     = (r_state == S_SEND) ? r_buf[r_rd_ptr[IW-1:0]] : '0;

    always_comb begin
        w_pass = r_buf;
        for (int i = 0; i < SIZE - 1; i++) begin
            if ((i[0] == r_pass_cnt[0]) && (r_buf[i+1] < r_buf[i])) begin
                w_pass[i]   = r_buf[i+1];
                w_pass[i+1] = r_buf[i];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_COLLECT;
        end else begin
            unique case (r_state)
                S_COLLECT: if (r_wr_cnt == FULL) w_next = S_SORT;
                S_SORT:    if (r_pass_cnt == LAST) w_next = S_SEND;
                S_SEND:    if (shift && (r_rd_ptr == LAST)) w_next = S_COLLECT;
                default:   w_next = S_COLLECT;
            endcase
        end
    end

    // done is a flop loaded from next state so the consumer sees a clean edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_SEND);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt   <= '0;
            r_pass_cnt <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < SIZE; i++) r_buf[i] <= '0;
        end else if (flush) begin
            r_wr_cnt   <= '0;
            r_pass_cnt <= '0;
            r_rd_ptr   <= '0;
        end else begin
            unique case (r_state)
                S_COLLECT: begin
                    if (r_wr_cnt == FULL) begin
                        r_wr_cnt <= '0;
                    end else if (in_valid) begin
                        r_buf[r_wr_cnt[IW-1:0]] <= in_data;
                        r_wr_cnt <= r_wr_cnt + CW'(1);
                    end
                end
                S_SORT: begin
                    r_buf      <= w_pass;
                    r_pass_cnt <= (r_pass_cnt == LAST) ? '0 : r_pass_cnt + CW'(1);
                    r_rd_ptr   <= '0;
                end
                S_SEND: begin
                    if (shift)
                        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + CW'(1);
                end
                default: begin
                    r_wr_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lower_layer_sender.sv
// Directed bench for lower_layer_sender: latency, ordering, stalls,
// ignored inputs, flush/reset recovery and a two-run merge.
module tb_lower_layer_sender;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, flush, shift;
    logic [7:0] in_data;
    logic       in_ready, done;
    logic [7:0] dout;
    logic       in_valid_r, shift_r;
    logic [7:0] in_data_r;
    logic       in_ready_r, done_r;
    logic [7:0] dout_r;

    int vec  = 0;
    int miss = 0;
    int rise_l = 0;
    int rise_r = 0;
    logic prev_l = 1'b0;
    logic prev_r = 1'b0;

    always #5 clk = ~clk;

    lower_layer_sender #(.SIZE(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .shift(shift),
        .dout(dout), .done(done)
    );

    lower_layer_sender #(.SIZE(4), .DATA_WIDTH(8)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_r), .in_data(in_data_r),
        .in_ready(in_ready_r), .flush(flush), .shift(shift_r),
        .dout(dout_r), .done(done_r)
    );

    always @(posedge clk) begin
        if (done && !prev_l) rise_l <= rise_l + 1;
        if (done_r && !prev_r) rise_r <= rise_r + 1;
        prev_l <= done;
        prev_r <= done_r;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] v, input bit gap);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[31-8*i -: 8];
            vec++;
            if (in_ready !== 1'b1) begin
                miss++;
                $display("FAIL feed_ready[%0d]: got %b expected 1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            if (gap && i < 3) tick();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vec++;
        if (done !== 1'b1) begin
            miss++;
            $display("FAIL wait_done: done=%b after %0d cycles, expected 1", done, n);
        end
    endtask

    task automatic pop_all(input logic [31:0] e);
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (dout !== e[31-8*i -: 8] || done !== 1'b1) begin
                miss++;
                $display("FAIL pop[%0d]: dout=%0d done=%b expected dout=%0d done=1",
                         i, dout, done, e[31-8*i -: 8]);
            end
            shift = 1'b1;
            tick();
            shift = 1'b0;
        end
        vec++;
        if (done !== 1'b0 || in_ready !== 1'b1 || dout !== 8'd0) begin
            miss++;
            $display("FAIL after_pops: done=%b in_ready=%b dout=%0d expected 0/1/0",
                     done, in_ready, dout);
        end
    endtask

    task automatic check_idle(input string nm);
        vec++;
        if (done !== 1'b0 || in_ready !== 1'b1 || dout !== 8'd0) begin
            miss++;
            $display("FAIL %s: done=%b in_ready=%b dout=%0d expected 0/1/0",
                     nm, done, in_ready, dout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_idle("reset");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        feed({8'd9, 8'd3, 8'd7, 8'd1}, 1'b0);
        for (int k = 1; k <= 4; k++) tick();
        vec++;
        if (done !== 1'b0) begin
            miss++;
            $display("FAIL latency_early: done=%b expected 0 after t+4", done);
        end
        tick();
        vec++;
        if (done !== 1'b1) begin
            miss++;
            $display("FAIL latency: done=%b expected 1 after t+5", done);
        end
        pop_all({8'd1, 8'd3, 8'd7, 8'd9});
    endtask

    task automatic test_dups_unsigned();
        feed({8'd5, 8'd5, 8'd2, 8'd5}, 1'b0);
        wait_done();
        pop_all({8'd2, 8'd5, 8'd5, 8'd5});
        feed({8'd255, 8'd0, 8'd128, 8'd0}, 1'b0);
        wait_done();
        pop_all({8'd0, 8'd0, 8'd128, 8'd255});
    endtask

    task automatic test_gaps_hold();
        feed({8'd6, 8'd4, 8'd8, 8'd2}, 1'b1);
        wait_done();
        for (int k = 0; k < 10; k++) begin
            tick();
            vec++;
            if (dout !== 8'd2 || done !== 1'b1) begin
                miss++;
                $display("FAIL hold[%0d]: dout=%0d done=%b expected 2/1", k, dout, done);
            end
        end
        pop_all({8'd2, 8'd4, 8'd6, 8'd8});
    endtask

    task automatic test_ignore();
        shift = 1'b1;
        feed({8'd20, 8'd10, 8'd40, 8'd30}, 1'b0);
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (dout !== 8'd0 || done !== 1'b0) begin
                miss++;
                $display("FAIL shift_ignored[%0d]: dout=%0d done=%b expected 0/0",
                         k, dout, done);
            end
            tick();
        end
        shift = 1'b0;
        tick();
        vec++;
        if (done !== 1'b1) begin
            miss++;
            $display("FAIL ignore_latency: done=%b expected 1", done);
        end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'd0;
            tick();
            vec++;
            if (dout !== 8'd10 || in_ready !== 1'b0) begin
                miss++;
                $display("FAIL valid_in_send[%0d]: dout=%0d in_ready=%b expected 10/0",
                         k, dout, in_ready);
            end
        end
        in_valid = 1'b0;
        pop_all({8'd10, 8'd20, 8'd30, 8'd40});
    endtask

    task automatic test_flush_reset();
        in_valid = 1'b1;
        in_data  = 8'd50;
        tick();
        in_data  = 8'd60;
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle("flush_collect");
        feed({8'd8, 8'd6, 8'd4, 8'd2}, 1'b0);
        wait_done();
        pop_all({8'd2, 8'd4, 8'd6, 8'd8});

        feed({8'd13, 8'd11, 8'd12, 8'd10}, 1'b0);
        wait_done();
        for (int k = 0; k < 2; k++) begin
            shift = 1'b1;
            tick();
        end
        shift = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle("flush_send");
        feed({8'd3, 8'd1, 8'd2, 8'd0}, 1'b0);
        wait_done();
        pop_all({8'd0, 8'd1, 8'd2, 8'd3});

        feed({8'd9, 8'd9, 8'd9, 8'd9}, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_idle("reset_mid_sort");
        #1;
        rst_n = 1'b1;
        tick();
        feed({8'd7, 8'd5, 8'd6, 8'd4}, 1'b0);
        wait_done();
        pop_all({8'd4, 8'd5, 8'd6, 8'd7});
    endtask

    task automatic test_merge();
        logic [31:0] a = {8'd4, 8'd8, 8'd1, 8'd6};
        logic [31:0] b = {8'd2, 8'd7, 8'd3, 8'd5};
        logic [7:0]  got [8];
        int nl0, nr0, n, cyc;
        nl0 = rise_l;
        nr0 = rise_r;
        for (int i = 0; i < 4; i++) begin
            in_valid   = 1'b1;
            in_data    = a[31-8*i -: 8];
            in_valid_r = 1'b1;
            in_data_r  = b[31-8*i -: 8];
            tick();
        end
        in_valid   = 1'b0;
        in_valid_r = 1'b0;
        wait_done();
        n = 0;
        cyc = 0;
        while (n < 8 && cyc < 40) begin
            shift   = 1'b0;
            shift_r = 1'b0;
            if (done && (!done_r || dout <= dout_r)) begin
                got[n] = dout;
                n++;
                shift = 1'b1;
            end else if (done_r) begin
                got[n] = dout_r;
                n++;
                shift_r = 1'b1;
            end
            tick();
            cyc++;
        end
        shift   = 1'b0;
        shift_r = 1'b0;
        tick();
        tick();
        vec++;
        if (n != 8) begin
            miss++;
            $display("FAIL merge_count: got %0d elements expected 8", n);
        end
        for (int k = 0; k < 8; k++) begin
            vec++;
            if (k >= n || got[k] !== 8'(k + 1)) begin
                miss++;
                $display("FAIL merge[%0d]: got %0d expected %0d", k, got[k], k + 1);
            end
        end
        vec++;
        if (rise_l - nl0 != 1 || rise_r - nr0 != 1) begin
            miss++;
            $display("FAIL done_edges: left=%0d right=%0d expected 1/1",
                     rise_l - nl0, rise_r - nr0);
        end
    endtask

    initial begin
        in_valid   = 1'b0;
        in_data    = 8'd0;
        flush      = 1'b0;
        shift      = 1'b0;
        in_valid_r = 1'b0;
        in_data_r  = 8'd0;
        shift_r    = 1'b0;
        test_reset();
        test_basic();
        test_dups_unsigned();
        test_gaps_hold();
        test_ignore();
        test_flush_reset();
        test_merge();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/lower_layer_sender.md
LOWER_LAYER_SENDER -- requirements
Module: lower_layer_sender

Interface
REQ-001 SHALL have parameter SIZE, default 4, elements per sorted run (SIZE >= 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  unsorted element present on in_data.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  unsorted element, unsigned.
REQ-007 SHALL have port in_ready  output  1  block accepts an element this cycle.
REQ-008 SHALL have port flush  input  1  synchronous abort of the current run.
REQ-009 SHALL have port shift  input  1  upper layer pops the current dout element.
REQ-010 SHALL have port dout  output  DATA_WIDTH  current smallest unsent element of the sorted run, driving upper-layer din1/din2.
REQ-011 SHALL have port done  output  1  level, high while a sorted run is available, driving upper-layer done_L/done_R.

Function
REQ-012 SHALL implement a three-state FSM: COLLECT, SORT, SEND.
REQ-013 In COLLECT, in_ready SHALL be 1; each cycle with in_valid=1 SHALL write in_data to buf[wr_cnt] and increment wr_cnt.
REQ-014 The acceptance that brings wr_cnt to SIZE SHALL move the FSM to SORT on the next edge, with wr_cnt cleared.
REQ-015 In SORT, in_ready SHALL be 0; the block SHALL perform one odd-even transposition pass per cycle for exactly SIZE cycles, tracked by pass counter pass_cnt.
REQ-016 Even pass_cnt SHALL compare-swap pairs (0,1),(2,3)...; odd pass_cnt SHALL compare-swap (1,2),(3,4)...; the swap places the smaller value at the lower index.
REQ-017 Comparison SHALL be unsigned strict less-than; equal values SHALL not swap.
REQ-018 After pass SIZE-1 the FSM SHALL enter SEND, with rd_ptr=0.
REQ-019 Latency: with the last element accepted at edge t, done SHALL be 1 after edge t+SIZE+1.
REQ-020 In SEND, done SHALL be 1, in_ready 0, and dout SHALL equal buf[rd_ptr] (ascending order).
REQ-021 In SEND, shift=1 SHALL increment rd_ptr; the pop with rd_ptr=SIZE-1 SHALL return the FSM to COLLECT, so done is 0 and in_ready is 1 from the next cycle.
REQ-022 In COLLECT and SORT, shift SHALL be ignored and dout SHALL be 0; in_valid SHALL be ignored in SORT and SEND.
REQ-023 flush=1 in any state SHALL return the FSM to COLLECT and clear wr_cnt, pass_cnt and rd_ptr on the next edge; buffer contents are don't-care; flush has priority over in_valid and shift.
REQ-024 done SHALL be glitch-free: driven directly from registered state, rising once per run, so the consumer edge detector sees one rising edge per run.
REQ-025 Counters SHALL be $clog2(SIZE+1) bits wide and SHALL never wrap past SIZE.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously enter COLLECT, clear wr_cnt, pass_cnt and rd_ptr and all buf entries, and set done=0, dout=0 and in_ready=1 (in_ready=1 follows from COLLECT).
REQ-027 Reset asserted mid-SORT or mid-SEND SHALL discard the run, and the first element after release SHALL be stored at buf[0].

Verification (SIZE=4, DATA_WIDTH=8)
REQ-028 Feed 9,3,7,1 on 4 consecutive cycles, with last accept at edge t -> done rises after edge t+5, and popping each cycle yields dout 1,3,7,9, then done=0 and in_ready=1.
REQ-029 Feed 5,5,2,5 -> output 2,5,5,5; feed 255,0,128,0 -> output 0,0,128,255 (unsigned ordering).
REQ-030 Feed with in_valid gaps (1-cycle idle between elements) and hold shift=0 in SEND for 10 cycles -> dout stays at the minimum and done stays 1; pops then resume in order.
REQ-031 Assert shift during COLLECT and SORT, and assert in_valid during SEND -> no state change, dout=0 outside SEND, and the run is unaffected.
REQ-032 Assert flush after 2 accepted elements, then again after 2 pops, and assert rst_n=0 mid-SORT -> each time the block returns to COLLECT with done=0, and the next 4 elements form a correct, independent run.
REQ-033 Pair two instances on an upper-layer merge stage with runs {4,8,1,6} and {2,7,3,5} -> the consumer sees exactly one done rising edge per run, and the merged stream is 1..8.
